msix_irq_sender: RTL
====================

// Module: msix_irq_sender
// PURPOSE
//   Delivers MSI-X interrupts to the host: consumes the resolved {msg, addr} pairs returned by
//   msix_manager on its tx and rx irq response channels and turns each into one 4-byte
//   posted DMA write request. It arbitrates tx/rx round-robin, honours the function mask,
//   discards malformed table entries and keeps delivery/error statistics.
// PARAMETERS
//   DMA_ADDR_WIDTH  64  width of interrupt target address
//   IRQ_MSG         32  width of MSI-X message data (one dword)
//   CNT_WIDTH       32  width of each statistics counter
// PORTS
//   clk               in   1               clock
//   rst               in   1               synchronous reset, active-high
//   func_mask         in   1               MSI-X function mask; 1 = accept nothing new
//   tx_irq_rsp_msg    in   IRQ_MSG         tx vector message data
//   tx_irq_rsp_addr   in   DMA_ADDR_WIDTH  tx vector target address
//   tx_irq_rsp_valid  in   1               tx entry valid
//   tx_irq_rsp_ready  out  1               tx entry accepted
//   rx_irq_rsp_msg    in   IRQ_MSG         rx vector message data
//   rx_irq_rsp_addr   in   DMA_ADDR_WIDTH  rx vector target address
//   rx_irq_rsp_valid  in   1               rx entry valid
//   rx_irq_rsp_ready  out  1               rx entry accepted
//   dma_wr_req_valid  out  1               DMA write request valid
//   dma_wr_req_ready  in   1               DMA engine accepts request
//   dma_wr_req_addr   out  DMA_ADDR_WIDTH  write address (latched entry addr)
//   dma_wr_req_data   out  IRQ_MSG         write payload (latched entry msg)
//   dma_wr_req_len    out  13              byte count, constant 13'd4
//   tx_irq_sent_cnt   out  CNT_WIDTH       tx interrupts issued to DMA
//   rx_irq_sent_cnt   out  CNT_WIDTH       rx interrupts issued to DMA
//   irq_err_cnt       out  CNT_WIDTH       entries dropped as malformed
// BEHAVIOUR
//   - FSM states IDLE, ISSUE. Reset: state IDLE, last_grant=rx (tx wins first tie), latched
//     addr/data/src = 0, all counters 0, dma_wr_req_valid=0, both *_rsp_ready=0.
//   - IDLE: if func_mask=0 and any *_rsp_valid, grant one source combinationally:
//     only one valid -> that one; both valid -> source opposite to last_grant.
//     Granted source sees *_rsp_ready=1 this cycle (other 0); msg/addr/src latched at edge.
//     func_mask=1 -> both readys 0, entries held upstream (pending), nothing dropped.
//   - Check on accept: addr==0 or addr[1:0]!=0 -> malformed: irq_err_cnt+1, stay IDLE,
//     last_grant updated, no DMA request. Else -> ISSUE, last_grant=src.
//   - ISSUE: dma_wr_req_valid=1 with latched addr/data, len=4; outputs stable until accept.
//     On dma_wr_req_ready: increment tx_ or rx_irq_sent_cnt per src, go IDLE.
//     Both *_rsp_ready=0 in ISSUE. func_mask rising in ISSUE does not retract the request.
//   - dma_wr_req_addr/data hold last latched value outside ISSUE (don't-care, not zeroed).
//   - Throughput: max one interrupt per 2 cycles (accept cycle + issue cycle min).
//   - Counters wrap at 2^CNT_WIDTH (all-ones + 1 -> 0), no saturation.
//   - rst mid-ISSUE: request dropped, FSM IDLE, counters cleared next edge; upstream entry
//     already consumed is not replayed.
// TESTING
//   1 tx only: msg=32'hA5A5_0001, addr=64'hFEE0_1000 -> tx_ready 1 cycle; next cycle
//     dma valid, addr FEE0_1000, data A5A5_0001, len 4; ready=1 -> tx_irq_sent_cnt=1.
//   2 tx and rx valid together from reset, 4 rounds, dma_ready=1 -> grant order tx,rx,tx,rx;
//     tx_cnt=2, rx_cnt=2, one accept every 2 cycles.
//   3 rx addr=64'h0000_0000_0000_1002 -> rx_ready pulses, no dma valid, irq_err_cnt=1;
//     addr=0 -> irq_err_cnt=2.
//   4 func_mask=1 with tx valid for 10 cycles -> tx_ready stays 0; clear mask -> accepted
//     next cycle and delivered intact.
//   5 dma_ready=0 for 7 cycles in ISSUE -> valid/addr/data stable, new rx valid not accepted;
//     rst asserted cycle 5 -> valid=0 next cycle, all counters 0.
//   6 preload tx_irq_sent_cnt to 32'hFFFF_FFFF (force), one tx delivery -> counter 0.

Source files
------------

// File: rtl/msix_irq_sender.sv
// msix_irq_sender
//   Turns resolved MSI-X table entries ({msg, addr}) from the tx and rx irq
//   response channels into single-dword posted DMA writes. Round-robin
//   arbitration between tx and rx, function-mask gating, malformed-entry
//   discard and delivery/error statistics.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   func_mask                       1 = accept no new entries (held upstream)
//   tx_irq_rsp_{msg,addr,valid}     tx entry in;  tx_irq_rsp_ready = accepted
//   rx_irq_rsp_{msg,addr,valid}     rx entry in;  rx_irq_rsp_ready = accepted
//   dma_wr_req_{valid,addr,data,len} DMA write request out, dma_wr_req_ready in
//   tx_irq_sent_cnt, rx_irq_sent_cnt interrupts handed to the DMA engine
//   irq_err_cnt                     entries dropped as malformed
module msix_irq_sender #(
    parameter int DMA_ADDR_WIDTH = 64,
    parameter int IRQ_MSG        = 32,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      func_mask,
    input  logic [IRQ_MSG-1:0]        tx_irq_rsp_msg,
    input  logic [DMA_ADDR_WIDTH-1:0] tx_irq_rsp_addr,
    input  logic                      tx_irq_rsp_valid,
    output logic                      tx_irq_rsp_ready,
    input  logic [IRQ_MSG-1:0]        rx_irq_rsp_msg,
    input  logic [DMA_ADDR_WIDTH-1:0] rx_irq_rsp_addr,
    input  logic                      rx_irq_rsp_valid,
    output logic                      rx_irq_rsp_ready,
    output logic                      dma_wr_req_valid,
    input  logic                      dma_wr_req_ready,
    output logic [DMA_ADDR_WIDTH-1:0] dma_wr_req_addr,
    output logic [IRQ_MSG-1:0]        dma_wr_req_data,
    output logic [12:0]               dma_wr_req_len,
    output logic [CNT_WIDTH-1:0]      tx_irq_sent_cnt,
    output logic [CNT_WIDTH-1:0]      rx_irq_sent_cnt,
    output logic [CNT_WIDTH-1:0]      irq_err_cnt
);

    typedef enum logic {IDLE, ISSUE} state_t;

    localparam logic                 SRC_TX  = 1'b0;
    localparam logic                 SRC_RX  = 1'b1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [DMA_ADDR_WIDTH-1:0] addr;
        logic [IRQ_MSG-1:0]        msg;
        logic                      src;
    } entry_t;

    state_t state, state_nxt;
    entry_t lat_q, sel;
    logic   last_grant;
    logic   gnt_tx, gnt_rx, accept, malformed, deliver;
    logic [CNT_WIDTH-1:0] tx_cnt_q, rx_cnt_q, err_cnt_q;

    // Grant: a lone valid wins; on a tie the source not served last wins.
    // Suppressed during reset so no upstream entry is consumed and lost.
    always_comb begin
        gnt_tx = 1'b0;
        gnt_rx = 1'b0;
        if (!rst && state == IDLE && !func_mask) begin
            if (tx_irq_rsp_valid && (!rx_irq_rsp_valid || last_grant == SRC_RX))
                gnt_tx = 1'b1;
            else if (rx_irq_rsp_valid)
                gnt_rx = 1'b1;
        end
    end

    always_comb begin
        sel.src  = gnt_rx ? SRC_RX : SRC_TX;
        sel.addr = gnt_rx ? rx_irq_rsp_addr : tx_irq_rsp_addr;
        sel.msg  = gnt_rx ? rx_irq_rsp_msg  : tx_irq_rsp_msg;
    end

    assign accept    = gnt_tx | gnt_rx;
    // Null or non-dword-aligned targets cannot be a valid MSI-X write.
    assign malformed = (sel.addr == '0) || (sel.addr[1:0] != 2'b00);
    assign deliver   = (state == ISSUE) && dma_wr_req_ready;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !malformed) state_nxt = ISSUE;
            ISSUE:   if (dma_wr_req_ready)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        tx_irq_rsp_ready = gnt_tx;
        rx_irq_rsp_ready = gnt_rx;
        dma_wr_req_valid = (state == ISSUE);
        dma_wr_req_addr  = lat_q.addr;
        dma_wr_req_data  = lat_q.msg;
        dma_wr_req_len   = 13'd4;
    end

    // Entry latch and arbitration history; malformed entries also move
    // last_grant so a stuck bad source cannot starve the other one.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q      <= '0;
            last_grant <= SRC_RX;
        end else if (accept) begin
            lat_q      <= sel;
            last_grant <= sel.src;
        end
    end

    // Statistics, free-running wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            if (accept && malformed)
                err_cnt_q <= err_cnt_q + CNT_ONE;
            if (deliver && lat_q.src == SRC_TX)
                tx_cnt_q <= tx_cnt_q + CNT_ONE;
            if (deliver && lat_q.src == SRC_RX)
                rx_cnt_q <= rx_cnt_q + CNT_ONE;
        end
    end

    assign tx_irq_sent_cnt = tx_cnt_q;
    assign rx_irq_sent_cnt = rx_cnt_q;
    assign irq_err_cnt     = err_cnt_q;

endmodule
